cv32e40p_vector_load_unit: RTL and testbench

CV32E40P_VECTOR_LOAD_UNIT -- requirements
Module: cv32e40p_vector_load_unit

---
 rtl/cv32e40p_vector_load_unit_if.sv | 35 +++
 rtl/cv32e40p_vector_load_unit.sv | 148 ++++++++++++++
 tb/tb_cv32e40p_vector_load_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_vector_load_unit_if.sv
// Request, memory-port and writeback/scoreboard signals of the vector load unit.
// The slave modport is the unit itself; the master modport is its environment.
interface cv32e40p_vector_load_unit_if #(
  parameter int VREG_AW = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [VREG_AW-1:0] req_vd;
  logic [31:0]        req_addr;
  logic [3:0]         req_mask;
  logic               data_req_o;
  logic               data_gnt_i;
  logic [31:0]        data_addr_o;
  logic               data_rvalid_i;
  logic [31:0]        data_rdata_i;
  logic               vrf_we;
  logic [VREG_AW-1:0] vrf_waddr;
  logic [127:0]       vrf_wdata;
  logic [3:0]         vrf_wmask;
  logic               sb_fire;
  logic [VREG_AW-1:0] sb_dest;
  logic               err_o;

  modport slave (
    input  req_valid, req_vd, req_addr, req_mask, data_gnt_i, data_rvalid_i, data_rdata_i,
    output req_ready, data_req_o, data_addr_o, vrf_we, vrf_waddr, vrf_wdata, vrf_wmask,
           sb_fire, sb_dest, err_o
  );

  modport master (
    output req_valid, req_vd, req_addr, req_mask, data_gnt_i, data_rvalid_i, data_rdata_i,
    input  req_ready, data_req_o, data_addr_o, vrf_we, vrf_waddr, vrf_wdata, vrf_wmask,
           sb_fire, sb_dest, err_o
  );
endinterface

// File: rtl/cv32e40p_vector_load_unit.sv
// Masked 4x32-bit vector load: one word beat per enabled lane, single 128-bit writeback.
// state | meaning
// IDLE  | ready for a request
// ISSUE | driving the memory request for the current lane
// WAIT  | granted, waiting for read data of the current lane
// WB    | registered writeback to the vector register file is active
module cv32e40p_vector_load_unit #(
  parameter int NUM_VREGS = 11,
  parameter int VREG_AW   = 4
) (
  input logic clk,
  input logic rst_n,
  cv32e40p_vector_load_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  localparam logic [VREG_AW:0] NUM_VREGS_W = (VREG_AW+1)'(NUM_VREGS);

  state_t             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [VREG_AW-1:0] vd_q;
  logic [31:0]        base_q;
  logic [3:0]         mask_q;
  logic [127:0]       buf_q, buf_upd;
  logic               err_q;
  logic               vrf_we_q;
  logic [VREG_AW-1:0] vrf_waddr_q;
  logic [127:0]       vrf_wdata_q;
  logic [3:0]         vrf_wmask_q;
  logic               vd_legal, accept, start, beat_done, has_next;
  logic [1:0]         first_lane, next_lane;

  assign vd_legal      = {1'b0, bus.req_vd} < NUM_VREGS_W;
  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign start         = accept && vd_legal && (bus.req_mask != 4'b0000);
  assign beat_done     = (state_q == WAIT) && bus.data_rvalid_i;

  always_comb begin
    first_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req_mask[i]) first_lane = 2'(i);
    end
    next_lane = 2'd0;
    has_next  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(lane_q))) begin
        next_lane = 2'(i);
        has_next  = 1'b1;
      end
    end
  end

  always_comb begin
    buf_upd = buf_q;
    buf_upd[{lane_q, 5'b00000} +: 32] = bus.data_rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    lane_d          = lane_q;
    bus.data_req_o  = 1'b0;
    bus.data_addr_o = 32'd0;
    bus.sb_fire     = 1'b0;
    bus.sb_dest     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          lane_d      = first_lane;
          bus.sb_fire = 1'b1;
          bus.sb_dest = bus.req_vd;
        end
      end
      ISSUE: begin
        bus.data_req_o  = 1'b1;
        bus.data_addr_o = base_q + {28'd0, lane_q, 2'b00};
        if (bus.data_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (bus.data_rvalid_i) begin
          if (has_next) begin
            state_d = ISSUE;
            lane_d  = next_lane;
          end else begin
            state_d = WB;
          end
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writeback fields are loaded on the final beat so they are valid exactly while in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vd_q        <= '0;
      base_q      <= 32'd0;
      mask_q      <= 4'd0;
      buf_q       <= 128'd0;
      err_q       <= 1'b0;
      vrf_we_q    <= 1'b0;
      vrf_waddr_q <= '0;
      vrf_wdata_q <= 128'd0;
      vrf_wmask_q <= 4'd0;
    end else begin
      err_q       <= accept && !vd_legal;
      vrf_we_q    <= 1'b0;
      vrf_waddr_q <= '0;
      vrf_wdata_q <= 128'd0;
      vrf_wmask_q <= 4'd0;
      if (accept) begin
        vd_q   <= bus.req_vd;
        base_q <= bus.req_addr;
        mask_q <= bus.req_mask;
        buf_q  <= 128'd0;
      end
      if (beat_done) begin
        buf_q <= buf_upd;
        if (!has_next) begin
          vrf_we_q    <= 1'b1;
          vrf_waddr_q <= vd_q;
          vrf_wdata_q <= buf_upd;
          vrf_wmask_q <= mask_q;
        end
      end
    end
  end

  assign bus.vrf_we    = vrf_we_q;
  assign bus.vrf_waddr = vrf_waddr_q;
  assign bus.vrf_wdata = vrf_wdata_q;
  assign bus.vrf_wmask = vrf_wmask_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_cv32e40p_vector_load_unit.sv
// Scoreboard bench for the vector load unit: expected beats and writebacks are queued at
// request time and retired by a memory responder and a writeback monitor.
module tb_cv32e40p_vector_load_unit;

  typedef struct {
    logic [3:0]   vd;
    logic [127:0] data;
    logic [3:0]   mask;
  } wr_t;

  logic clk;
  logic rst_n;

  cv32e40p_vector_load_unit_if #(.VREG_AW(4)) vif ();

  cv32e40p_vector_load_unit #(.NUM_VREGS(11), .VREG_AW(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (vif)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int we_cyc = 0;
  int sb_cnt = 0, err_cnt = 0, we_cnt = 0, grants = 0;
  int extra_we = 0, extra_beats = 0;
  int stall_left = 0, stall_seen = 0;
  bit inject_rv = 0, hold_resp = 0, pend = 0;
  logic [31:0] pend_addr, stall_addr;
  logic [31:0] aq[$];
  wr_t wq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a[31:4] == 28'h0000100) return 32'h000000A0 + {28'd0, a[3:2]};
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory responder: grant (optionally after a stall), read data one cycle after grant.
  initial begin
    vif.data_gnt_i    = 1'b0;
    vif.data_rvalid_i = 1'b0;
    vif.data_rdata_i  = 32'd0;
    forever begin
      @(negedge clk);
      vif.data_gnt_i    = 1'b0;
      vif.data_rvalid_i = 1'b0;
      vif.data_rdata_i  = 32'd0;
      if (pend && !hold_resp) begin
        vif.data_rvalid_i = 1'b1;
        vif.data_rdata_i  = mem_data(pend_addr);
        pend = 0;
      end
      if (vif.data_req_o) begin
        if (stall_left > 0) begin
          if (stall_seen == 0) stall_addr = vif.data_addr_o;
          else chk("stall_addr", vif.data_addr_o, stall_addr);
          stall_seen++;
          stall_left--;
          if (inject_rv && !vif.data_rvalid_i) begin
            vif.data_rvalid_i = 1'b1;
            vif.data_rdata_i  = 32'hDEAD_BEEF;
          end
        end else begin
          vif.data_gnt_i = 1'b1;
          grants++;
          pend      = 1;
          pend_addr = vif.data_addr_o;
          if (aq.size() == 0) begin
            extra_beats++;
            chk("addr_extra", extra_beats, 0);
          end else begin
            chk("data_addr", vif.data_addr_o, aq.pop_front());
          end
        end
      end
    end
  end

  // Writeback / pulse monitor.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (vif.sb_fire) sb_cnt++;
      if (vif.err_o) err_cnt++;
      if (vif.vrf_we) begin
        we_cnt++;
        we_cyc = cyc;
        if (wq.size() == 0) begin
          extra_we++;
          chk("we_extra", extra_we, 0);
        end else begin
          e = wq.pop_front();
          chk("vrf_waddr", vif.vrf_waddr, e.vd);
          chk("vrf_wdata", vif.vrf_wdata, e.data);
          chk("vrf_wmask", vif.vrf_wmask, e.mask);
        end
      end else if ({vif.vrf_waddr, vif.vrf_wdata, vif.vrf_wmask} != '0) begin
        chk("vrf_zero", {vif.vrf_waddr, vif.vrf_wdata, vif.vrf_wmask}, 0);
      end
    end
  end

  task automatic send(input logic [3:0] vd, input logic [31:0] addr, input logic [3:0] mask,
                      input bit expect_wr);
    wr_t e;
    logic [31:0] a;
    bit go;
    go = (vd < 4'd11) && (mask != 4'b0000);
    @(negedge clk);
    vif.req_valid = 1'b1;
    vif.req_vd    = vd;
    vif.req_addr  = addr;
    vif.req_mask  = mask;
    #1;
    chk("req_ready", vif.req_ready, 1);
    chk("sb_fire", vif.sb_fire, go);
    if (go) chk("sb_dest", vif.sb_dest, vd);
    acc_cyc = cyc;
    if (go) begin
      e.vd   = vd;
      e.mask = mask;
      e.data = '0;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          a = addr + 32'(4 * i);
          aq.push_back(a);
          e.data[32*i +: 32] = mem_data(a);
        end
      end
      if (expect_wr) wq.push_back(e);
    end
    @(posedge clk);
    #1;
    vif.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (wq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("wb_timeout", wq.size(), 0);
    repeat (2) @(posedge clk);
    chk("beats_left", aq.size(), 0);
  endtask

  initial begin
    int sb0, err0, we0, g0, n;
    rst_n = 1'b0;
    vif.req_valid = 1'b1;
    vif.req_vd    = 4'd3;
    vif.req_addr  = 32'h1000;
    vif.req_mask  = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", vif.req_ready, 0);
    chk("rst_data_req", vif.data_req_o, 0);
    chk("rst_sb_fire", vif.sb_fire, 0);
    chk("rst_vrf_we", vif.vrf_we, 0);
    chk("rst_err", vif.err_o, 0);
    vif.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", vif.req_ready, 1);

    // Full load with latency check.
    sb0 = sb_cnt; we0 = we_cnt;
    send(4'd3, 32'h1000, 4'b1111, 1);
    wait_done(100);
    chk("full_latency", we_cyc - acc_cyc, 9);
    chk("full_sb_cnt", sb_cnt - sb0, 1);
    chk("full_we_cnt", we_cnt - we0, 1);

    // Sparse mask.
    g0 = grants;
    send(4'd1, 32'h2000, 4'b1010, 1);
    wait_done(100);
    chk("sparse_beats", grants - g0, 2);

    // Grant stall with stray rvalid during ISSUE.
    stall_seen = 0; stall_left = 5; inject_rv = 1;
    send(4'd7, 32'h4000, 4'b1111, 1);
    wait_done(200);
    chk("stall_cycles", stall_seen, 5);
    inject_rv = 0;

    // Illegal vd.
    sb0 = sb_cnt; err0 = err_cnt; we0 = we_cnt; g0 = grants;
    send(4'd12, 32'h5000, 4'b1111, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("ill_err_cnt", err_cnt - err0, 1);
    chk("ill_sb_cnt", sb_cnt - sb0, 0);
    chk("ill_beats", grants - g0, 0);
    chk("ill_we_cnt", we_cnt - we0, 0);
    chk("ill_ready", vif.req_ready, 1);

    // Empty mask.
    sb0 = sb_cnt; err0 = err_cnt; we0 = we_cnt; g0 = grants;
    send(4'd2, 32'h6000, 4'b0000, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("m0_err_cnt", err_cnt - err0, 0);
    chk("m0_sb_cnt", sb_cnt - sb0, 0);
    chk("m0_beats", grants - g0, 0);
    chk("m0_we_cnt", we_cnt - we0, 0);

    // Address wrap.
    send(4'd10, 32'hFFFF_FFF8, 4'b1111, 1);
    wait_done(100);

    // Reset while waiting for read data; late rvalid must be ignored.
    we0 = we_cnt; g0 = grants; hold_resp = 1;
    send(4'd5, 32'h3000, 4'b1111, 0);
    n = 0;
    while (grants == g0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("rst_grant_seen", grants - g0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_req", vif.data_req_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_resp = 0;
    aq.delete();
    repeat (5) @(negedge clk);
    #3;
    chk("midrst_we_cnt", we_cnt - we0, 0);
    chk("midrst_ready", vif.req_ready, 1);
    send(4'd6, 32'h7000, 4'b0111, 1);
    wait_done(100);

    // Random traffic with occasional grant stalls.
    for (int k = 0; k < 6; k++) begin
      stall_seen = 0;
      stall_left = $urandom_range(0, 3);
      send(4'($urandom_range(0, 10)), {$urandom, 2'b00} , 4'($urandom_range(1, 15)), 1);
      wait_done(200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
